// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM states,
// digit width, the reverse double-dabble correction constants, and a
// digit-validity helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         DIG_W       = 4;
  localparam logic [3:0] CORR_THRESH = 4'd8;
  localparam logic [3:0] CORR_VAL    = 4'd3;

  // A BCD digit is only legal in the range 0..9.
  function automatic logic digit_bad(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_to_bin_sub3.sv
// sub3: reverse double-dabble correction cell, the inverse of the add3 cell
// in the binary-to-BCD path. Values 8..15 have 3 subtracted (mod 16).
module sub3
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] i_d,
  output logic [DIG_W-1:0] o_d
);

  assign o_d = (i_d >= CORR_THRESH) ? (i_d - CORR_VAL) : i_d;

endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential BCD-to-binary converter using reverse double-dabble,
// one right shift plus per-digit subtract-3 correction per clock.
// Optional feature macro: BCD2BIN_ERR_CHECK_EN (rejects digits > 9 at
// acceptance with err=1, bin_out=0 and a one-cycle path to DONE).
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic                  CLOCK_50,
  input  logic                  RST,
  input  logic                  start,
  input  logic [4*NDIG-1:0]     bcd_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [BW-1:0]         bin_out,
  output logic                  err
);

  localparam int DW = DIG_W * NDIG;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BW - 1);

  state_t          r_state, w_state;
  logic [DW-1:0]   r_digits, w_digits;
  logic [BW-1:0]   r_bin, w_bin;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [BW-1:0]   r_bin_out, w_bin_out;
  logic            r_err, w_err;
  logic            r_ready, r_busy, r_done;

  logic [DW-1:0]   w_sh_digits;
  logic [DW-1:0]   w_cor_digits;
  logic [BW-1:0]   w_sh_bin;
  logic            w_bad;

  // The ONES LSB falls out of the digit register into the binary MSB.
  assign w_sh_digits = {1'b0, r_digits[DW-1:1]};
  assign w_sh_bin    = {r_digits[0], r_bin[BW-1:1]};

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_corr
      sub3 u_sub3 (
        .i_d (w_sh_digits[g*DIG_W +: DIG_W]),
        .o_d (w_cor_digits[g*DIG_W +: DIG_W])
      );
    end
  endgenerate

`ifdef BCD2BIN_ERR_CHECK_EN
  // Flag any non-BCD digit on the incoming request.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (digit_bad(bcd_in[i*DIG_W +: DIG_W])) begin
        w_bad = 1'b1;
      end else begin
        w_bad = w_bad;
      end
    end
  end
`else
  assign w_bad = 1'b0;
`endif

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    w_state   = r_state;
    w_digits  = r_digits;
    w_bin     = r_bin;
    w_cnt     = r_cnt;
    w_bin_out = r_bin_out;
    w_err     = r_err;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_digits = bcd_in;
          w_bin    = '0;
          if (w_bad) begin
            w_bin_out = '0;
            w_err     = 1'b1;
            w_state   = DONE;
          end else begin
            w_err   = 1'b0;
            w_cnt   = '0;
            w_state = SHIFT;
          end
        end else begin
          w_state = IDLE;
        end
      end
      SHIFT: begin
        w_digits = w_cor_digits;
        w_bin    = w_sh_bin;
        if (r_cnt == CNT_LAST) begin
          // Digit register is all zero here; the binary register is final.
          w_bin_out = w_sh_bin;
          w_state   = DONE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_digits  <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_bin_out <= '0;
      r_err     <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_digits  <= w_digits;
      r_bin     <= w_bin;
      r_cnt     <= w_cnt;
      r_bin_out <= w_bin_out;
      r_err     <= w_err;
      r_ready   <= (w_state == IDLE);
      r_busy    <= (w_state == SHIFT);
      r_done    <= (w_state == DONE);
    end
  end

  assign ready   = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign bin_out = r_bin_out;
  assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed cases, randomized valid
// inputs against a decimal reference model, reset mid-conversion, and an
// exhaustive back-to-back sweep with done-spacing checks.
module tb_bcd_to_bin;

  localparam int NDIG = 3;
  localparam int BW   = 10;

  logic              CLOCK_50;
  logic              RST;
  logic              start;
  logic [4*NDIG-1:0] bcd_in;
  logic              ready, busy, done, err;
  logic [BW-1:0]     bin_out;

  int n_checks = 0;
  int n_errors = 0;

  bcd_to_bin #(.NDIG(NDIG), .BW(BW)) dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .start    (start),
    .bcd_in   (bcd_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .bin_out  (bin_out),
    .err      (err)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of the packed digits, most significant first.
  function automatic int bcd_value(input logic [4*NDIG-1:0] b);
    int v = 0;
    for (int i = NDIG - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [4*NDIG-1:0] enc(input int n);
    logic [4*NDIG-1:0] r = '0;
    int p = n;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    if (!ready) check_val({tag, "_ready_timeout"}, 32'(ready), 32'd1);
  endtask

  // Issue one request; check latency, err and (optionally) the result.
  task automatic run_conv(input string tag, input logic [4*NDIG-1:0] b,
                          input int exp_lat, input bit exp_err, input bit chk_bin);
    int lat = 0;
    wait_ready(tag);
    bcd_in = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_err"}, 32'(err), 32'(exp_err));
    if (chk_bin) begin
      if (exp_err) check_val({tag, "_bin"}, 32'(bin_out), 32'd0);
      else         check_val({tag, "_bin"}, 32'(bin_out), 32'(bcd_value(b)));
    end
  endtask

  initial begin
    logic [4*NDIG-1:0] rb;
    int exp_q[$];
    int got, t, last_done, next_idx;
    bit acc;

    RST    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    tick();
    tick();
    RST = 1'b0;
    tick();

    check_val("rst_ready", 32'(ready),   32'd1);
    check_val("rst_busy",  32'(busy),    32'd0);
    check_val("rst_done",  32'(done),    32'd0);
    check_val("rst_bin",   32'(bin_out), 32'd0);
    check_val("rst_err",   32'(err),     32'd0);

    // Busy/ready right after an accept edge.
    wait_ready("acc");
    bcd_in = 12'h255;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check_val("acc_busy",  32'(busy),  32'd1);
    check_val("acc_ready", 32'(ready), 32'd0);
    for (int i = 0; i < BW; i++) tick();
    check_val("c255_done", 32'(done),    32'd1);
    check_val("c255_bin",  32'(bin_out), 32'd255);
    tick();
    check_val("c255_done_pulse", 32'(done),  32'd0);
    check_val("c255_ready_back", 32'(ready), 32'd1);
    check_val("c255_bin_hold",   32'(bin_out), 32'd255);

    run_conv("c999", 12'h999, BW, 1'b0, 1'b1);
    run_conv("c000", 12'h000, BW, 1'b0, 1'b1);

    // A start during SHIFT is ignored.
    wait_ready("ign");
    bcd_in = 12'h128;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bcd_in = 12'h777;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    t = 0;
    while (!done && t < 40) begin
      tick();
      t++;
    end
    check_val("ign_lat", 32'(t), 32'(BW - 4));
    check_val("ign_bin", 32'(bin_out), 32'd128);
    tick();
    check_val("ign_not_queued", 32'(ready), 32'd1);
    tick();
    check_val("ign_still_idle", 32'(busy), 32'd0);
    run_conv("c777", 12'h777, BW, 1'b0, 1'b1);

    // Reset in the middle of a conversion.
    wait_ready("rmid");
    bcd_in = 12'h640;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    RST = 1'b1;
    #1;
    check_val("rmid_busy",  32'(busy),    32'd0);
    check_val("rmid_done",  32'(done),    32'd0);
    check_val("rmid_bin",   32'(bin_out), 32'd0);
    check_val("rmid_ready", 32'(ready),   32'd1);
    tick();
    RST = 1'b0;
    tick();
    run_conv("c042", 12'h042, BW, 1'b0, 1'b1);

`ifdef BCD2BIN_ERR_CHECK_EN
    // Bad digit: done and err visible right after the accept edge.
    run_conv("bad1a3", 12'h1A3, 0, 1'b1, 1'b1);
    run_conv("badf00", 12'hF00, 0, 1'b1, 1'b1);
    run_conv("clr_err", 12'h314, BW, 1'b0, 1'b1);
`else
    // Without the check, bad digits take the full path and err stays 0.
    run_conv("nochk1a3", 12'h1A3, BW, 1'b0, 1'b0);
    run_conv("nochk_ok", 12'h314, BW, 1'b0, 1'b1);
`endif

    // Randomized valid requests.
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < NDIG; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
      run_conv("rand", rb, BW, 1'b0, 1'b1);
    end

    // Exhaustive back-to-back sweep with start held high.
    wait_ready("sweep");
    tick();
    next_idx  = 0;
    bcd_in    = enc(0);
    start     = 1'b1;
    got       = 0;
    t         = 0;
    last_done = -1;
    while (got < 1000 && t < 13000) begin
      acc = ready && start;
      tick();
      t++;
      if (acc) begin
        exp_q.push_back(next_idx);
        next_idx++;
        if (next_idx < 1000) bcd_in = enc(next_idx);
        else start = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check_val("sweep_spurious_done", 32'd1, 32'd0);
        end else begin
          check_val("sweep_bin", 32'(bin_out), 32'(exp_q.pop_front()));
        end
        check_val("sweep_err", 32'(err), 32'd0);
        if (last_done >= 0) check_val("sweep_spacing", 32'(t - last_done), 32'(BW + 2));
        last_done = t;
        got++;
      end
    end
    start = 1'b0;
    if (got < 1000) check_val("sweep_timeout", 32'(got), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
